// File: rtl/cache_ctrl_if.sv
// ============================================================================
// cache_ctrl_if : CPU, memory and LRU-tracker signals of the cache controller.
// Optional CACHE_STATS_EN adds hit_count / miss_count.  Rev 1.0
// ============================================================================
`default_nettype none

interface cache_ctrl_if #(
  parameter int WAYS       = 4,
  parameter int TOTAL_SIZE = 16,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8
);
  localparam int c_SETS  = TOTAL_SIZE / WAYS;
  localparam int c_IDX_W = $clog2(c_SETS);
  localparam int c_WAY_W = $clog2(WAYS);

  logic                cpu_req_valid;
  logic                cpu_req_ready;
  logic                cpu_we;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [DATA_W-1:0]   cpu_wdata;
  logic                cpu_resp_valid;
  logic [DATA_W-1:0]   cpu_rdata;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_rdata;
  logic                lru_re;
  logic                lru_we;
  logic [c_WAY_W-1:0]  lru_way;
  logic [c_IDX_W-1:0]  lru_index;
  logic [c_WAY_W-1:0]  lru_replace_way;
`ifdef CACHE_STATS_EN
  logic [15:0]         hit_count;
  logic [15:0]         miss_count;
`endif

  // Controller side
  modport slave (
`ifdef CACHE_STATS_EN
    output hit_count, miss_count,
`endif
    input  cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata, lru_replace_way,
    output cpu_req_ready, cpu_resp_valid, cpu_rdata,
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    output lru_re, lru_we, lru_way, lru_index
  );

  // CPU / memory / tracker side
  modport master (
`ifdef CACHE_STATS_EN
    input  hit_count, miss_count,
`endif
    output cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata, lru_replace_way,
    input  cpu_req_ready, cpu_resp_valid, cpu_rdata,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  lru_re, lru_we, lru_way, lru_index
  );
endinterface

`default_nettype wire

// File: rtl/cache_ctrl.sv
// ============================================================================
// cache_ctrl : set-associative, write-through, read-allocate cache controller
// driving an external LRU tracker.  Optional macro: CACHE_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module cache_ctrl #(
  parameter int WAYS       = 4,
  parameter int TOTAL_SIZE = 16,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8
) (
  input  wire logic   clk,
  input  wire logic   rst,
  cache_ctrl_if.slave bus
);
  localparam int c_SETS  = TOTAL_SIZE / WAYS;
  localparam int c_IDX_W = $clog2(c_SETS);
  localparam int c_WAY_W = $clog2(WAYS);
  localparam int c_TAG_W = ADDR_W - c_IDX_W;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_MEM_RD   = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_WR_THRU  = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_WAY_W-1:0]  r_victim;

  logic [WAYS-1:0]     r_valid [c_SETS];
  logic [c_TAG_W-1:0]  r_tag   [c_SETS][WAYS];
  logic [DATA_W-1:0]   r_data  [c_SETS][WAYS];

  logic                r_req_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_mem_req_valid;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_lru_re;
  logic                r_lru_we;
  logic [c_WAY_W-1:0]  r_lru_way;

  logic [c_IDX_W-1:0]  w_idx;
  logic [c_TAG_W-1:0]  w_tag;
  logic                w_hit;
  logic [c_WAY_W-1:0]  w_hit_way;

  assign w_idx = r_addr[c_IDX_W-1:0];
  assign w_tag = r_addr[ADDR_W-1:c_IDX_W];

  // Scan from the top so the lowest-numbered matching way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = c_WAY_W'(w);
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;
  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      for (int s = 0; s < c_SETS; s++) r_valid[s] <= '0;
      r_addr          <= '0;
      r_we            <= 1'b0;
      r_wdata         <= '0;
      r_victim        <= '0;
      r_req_ready     <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_rdata         <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_lru_re        <= 1'b0;
      r_lru_we        <= 1'b0;
      r_lru_way       <= '0;
`ifdef CACHE_STATS_EN
      r_hit_count     <= '0;
      r_miss_count    <= '0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      r_lru_re     <= 1'b0;
      r_lru_we     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cpu_req_valid) begin
            r_addr      <= bus.cpu_addr;
            r_we        <= bus.cpu_we;
            r_wdata     <= bus.cpu_wdata;
            r_req_ready <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
`ifdef CACHE_STATS_EN
          if (w_hit && (r_hit_count != 16'hFFFF))
            r_hit_count <= r_hit_count + 16'd1;
          if (!w_hit && (r_miss_count != 16'hFFFF))
            r_miss_count <= r_miss_count + 16'd1;
`endif
          if (!r_we && w_hit) begin
            r_resp_valid <= 1'b1;
            r_rdata      <= r_data[w_idx][w_hit_way];
            r_lru_re     <= 1'b1;
            r_lru_way    <= w_hit_way;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end else if (!r_we) begin
            r_victim        <= bus.lru_replace_way;
            r_mem_req_valid <= 1'b1;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= r_addr;
            r_state         <= S_MEM_RD;
          end else begin
            // Stores always write through; only a hit touches the LRU.
            if (w_hit) begin
              r_lru_we  <= 1'b1;
              r_lru_way <= w_hit_way;
            end
            r_mem_req_valid <= 1'b1;
            r_mem_we        <= 1'b1;
            r_mem_addr      <= r_addr;
            r_mem_wdata     <= r_wdata;
            r_state         <= S_WR_THRU;
          end
        end
        S_MEM_RD: begin
          if (bus.mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (bus.mem_resp_valid) begin
            r_valid[w_idx][r_victim] <= 1'b1;
            r_lru_we     <= 1'b1;
            r_lru_way    <= r_victim;
            r_resp_valid <= 1'b1;
            r_rdata      <= bus.mem_rdata;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        S_WR_THRU: begin
          if (bus.mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_mem_we        <= 1'b0;
            r_resp_valid    <= 1'b1;
            r_req_ready     <= 1'b1;
            r_state         <= S_IDLE;
          end
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Data and tag storage is never cleared; writes are suppressed while rst is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      if ((r_state == S_LOOKUP) && r_we && w_hit)
        r_data[w_idx][w_hit_way] <= r_wdata;
      if ((r_state == S_MEM_WAIT) && bus.mem_resp_valid) begin
        r_data[w_idx][r_victim] <= bus.mem_rdata;
        r_tag[w_idx][r_victim]  <= w_tag;
      end
    end
  end

  assign bus.cpu_req_ready  = r_req_ready;
  assign bus.cpu_resp_valid = r_resp_valid;
  assign bus.cpu_rdata      = r_rdata;
  assign bus.mem_req_valid  = r_mem_req_valid;
  assign bus.mem_we         = r_mem_we;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_wdata      = r_mem_wdata;
  assign bus.lru_re         = r_lru_re;
  assign bus.lru_we         = r_lru_we;
  assign bus.lru_way        = r_lru_way;
  assign bus.lru_index      = w_idx;

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl.sv
// ============================================================================
// tb_cache_ctrl : directed vector bench for cache_ctrl with a true-LRU tracker
// model and a scripted memory.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_cache_ctrl;
  logic clk;
  logic rst;

  cache_ctrl_if #(.WAYS(4), .TOTAL_SIZE(16), .ADDR_W(8), .DATA_W(8)) bus ();

  cache_ctrl #(.WAYS(4), .TOTAL_SIZE(16), .ADDR_W(8), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // True-LRU tracker model: rank 0 = least recent; reset order makes way 0 the victim.
  logic [1:0] r_rank [4][4];
  logic [1:0] w_victim;

  always_comb begin
    w_victim = 2'd0;
    for (int w = 0; w < 4; w++)
      if (r_rank[bus.lru_index][w] == 2'd0) w_victim = 2'(w);
  end
  assign bus.lru_replace_way = w_victim;

  always @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 4; s++)
        for (int w = 0; w < 4; w++) r_rank[s][w] <= 2'(w);
    end else if (bus.lru_re || bus.lru_we) begin
      for (int w = 0; w < 4; w++) begin
        if (2'(w) == bus.lru_way)
          r_rank[bus.lru_index][w] <= 2'd3;
        else if (r_rank[bus.lru_index][w] > r_rank[bus.lru_index][bus.lru_way])
          r_rank[bus.lru_index][w] <= r_rank[bus.lru_index][w] - 2'd1;
      end
    end
  end

  int n_pass  = 0;
  int n_total = 0;
  logic r_both = 1'b0;

  always @(negedge clk) if (bus.lru_re && bus.lru_we) r_both = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic       pre_rst;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] mdata;
    int         delay;
    logic       exp_miss;
    logic [7:0] exp_rdata;
    logic       exp_re;
    logic       exp_wep;
    logic [1:0] exp_way;
  } vec_t;

  typedef struct {
    logic       got;
    int         lat;
    logic [7:0] rdata;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    int         mem_cycles;
    int         n_re;
    int         n_we;
    logic [1:0] way;
    logic [1:0] index;
  } obs_t;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("reset_req_ready",  32'(bus.cpu_req_ready), 32'd1);
    chk("reset_resp_valid", 32'(bus.cpu_resp_valid), 32'd0);
    chk("reset_mem_valid",  32'(bus.mem_req_valid), 32'd0);
    chk("reset_lru_pulse",  32'({bus.lru_re, bus.lru_we}), 32'd0);
    chk("reset_rdata",      32'(bus.cpu_rdata), 32'd0);
  endtask

  task automatic run_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] mdata, input int delay, output obs_t o);
    logic pend;
    o = '{default: 0};
    pend = 1'b0;
    @(negedge clk);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_we        = we;
    bus.cpu_addr      = addr;
    bus.cpu_wdata     = wdata;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus.cpu_req_valid  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (pend) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = mdata;
        pend = 1'b0;
      end
      if (bus.lru_re) o.n_re++;
      if (bus.lru_we) o.n_we++;
      if (bus.lru_re || bus.lru_we) begin
        o.way   = bus.lru_way;
        o.index = bus.lru_index;
      end
      bus.mem_req_ready = 1'b0;
      if (bus.mem_req_valid) begin
        o.mem_cycles++;
        o.mem_addr  = bus.mem_addr;
        o.mem_wdata = bus.mem_wdata;
        if (bus.mem_we) o.mem_wr = 1'b1;
        else            o.mem_rd = 1'b1;
        if (o.mem_cycles > delay) begin
          bus.mem_req_ready = 1'b1;
          if (!bus.mem_we) pend = 1'b1;
        end
      end
      if (bus.cpu_resp_valid) begin
        o.got   = 1'b1;
        o.lat   = k;
        o.rdata = bus.cpu_rdata;
        break;
      end
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
  endtask

  vec_t vecs[17];
  obs_t o;

  initial begin
    rst = 1'b0;
    bus.cpu_req_valid  = 1'b0;
    bus.cpu_we         = 1'b0;
    bus.cpu_addr       = '0;
    bus.cpu_wdata      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;

    //          rst we  addr   wdata  mdata  dly miss rdata  re  wep way
    vecs[0]  = '{1, 0, 8'h05, 8'h00, 8'hA5, 0, 1, 8'hA5, 0, 1, 2'd0};
    vecs[1]  = '{0, 0, 8'h05, 8'h00, 8'h00, 0, 0, 8'hA5, 1, 0, 2'd0};
    vecs[2]  = '{0, 1, 8'h05, 8'h3C, 8'h00, 0, 0, 8'h00, 0, 1, 2'd0};
    vecs[3]  = '{0, 0, 8'h05, 8'h00, 8'h00, 0, 0, 8'h3C, 1, 0, 2'd0};
    vecs[4]  = '{0, 1, 8'h21, 8'h77, 8'h00, 3, 1, 8'h00, 0, 0, 2'd0};
    vecs[5]  = '{0, 0, 8'h21, 8'h00, 8'h12, 0, 1, 8'h12, 0, 1, 2'd1};
    vecs[6]  = '{0, 0, 8'h20, 8'h00, 8'h34, 0, 1, 8'h34, 0, 1, 2'd0};
    vecs[7]  = '{0, 0, 8'h21, 8'h00, 8'h00, 0, 0, 8'h12, 1, 0, 2'd1};
    vecs[8]  = '{0, 0, 8'h05, 8'h00, 8'h00, 0, 0, 8'h3C, 1, 0, 2'd0};
    vecs[9]  = '{1, 0, 8'h01, 8'h00, 8'h11, 0, 1, 8'h11, 0, 1, 2'd0};
    vecs[10] = '{0, 0, 8'h05, 8'h00, 8'h55, 0, 1, 8'h55, 0, 1, 2'd1};
    vecs[11] = '{0, 0, 8'h09, 8'h00, 8'h99, 0, 1, 8'h99, 0, 1, 2'd2};
    vecs[12] = '{0, 0, 8'h0D, 8'h00, 8'hDD, 0, 1, 8'hDD, 0, 1, 2'd3};
    vecs[13] = '{0, 0, 8'h11, 8'h00, 8'hEE, 0, 1, 8'hEE, 0, 1, 2'd0};
    vecs[14] = '{0, 0, 8'h01, 8'h00, 8'h10, 0, 1, 8'h10, 0, 1, 2'd1};
    vecs[15] = '{0, 0, 8'h05, 8'h00, 8'h50, 0, 1, 8'h50, 0, 1, 2'd2};
    vecs[16] = '{0, 0, 8'h11, 8'h00, 8'h00, 0, 0, 8'hEE, 1, 0, 2'd0};

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].pre_rst) do_reset();
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mdata, vecs[i].delay, o);
      chk($sformatf("v%0d_resp", i), 32'(o.got), 32'd1);
      chk($sformatf("v%0d_ready_after", i), 32'(bus.cpu_req_ready), 32'd1);
      chk($sformatf("v%0d_lru_re", i), 32'(o.n_re), 32'(vecs[i].exp_re));
      chk($sformatf("v%0d_lru_we", i), 32'(o.n_we), 32'(vecs[i].exp_wep));
      if (vecs[i].exp_re || vecs[i].exp_wep) begin
        chk($sformatf("v%0d_lru_way", i), 32'(o.way), 32'(vecs[i].exp_way));
        chk($sformatf("v%0d_lru_index", i), 32'(o.index), 32'(vecs[i].addr[1:0]));
      end
      if (!vecs[i].we) begin
        chk($sformatf("v%0d_rdata", i), 32'(o.rdata), 32'(vecs[i].exp_rdata));
        chk($sformatf("v%0d_mem_rd", i), 32'(o.mem_rd), 32'(vecs[i].exp_miss));
        chk($sformatf("v%0d_no_mem_wr", i), 32'(o.mem_wr), 32'd0);
        if (vecs[i].exp_miss)
          chk($sformatf("v%0d_mem_addr", i), 32'(o.mem_addr), 32'(vecs[i].addr));
        else
          chk($sformatf("v%0d_hit_latency", i), 32'(o.lat), 32'd2);
      end else begin
        chk($sformatf("v%0d_mem_wr", i), 32'(o.mem_wr), 32'd1);
        chk($sformatf("v%0d_no_mem_rd", i), 32'(o.mem_rd), 32'd0);
        chk($sformatf("v%0d_wr_addr", i), 32'(o.mem_addr), 32'(vecs[i].addr));
        chk($sformatf("v%0d_wr_data", i), 32'(o.mem_wdata), 32'(vecs[i].wdata));
        chk($sformatf("v%0d_wr_cycles", i), 32'(o.mem_cycles), 32'(vecs[i].delay + 1));
      end
    end

    // Reset while waiting for refill data: the transaction must vanish.
    begin
      int   seen_resp;
      int   seen_lru;
      logic hs;
      seen_resp = 0;
      seen_lru  = 0;
      hs        = 1'b0;
      @(negedge clk);
      bus.cpu_req_valid = 1'b1;
      bus.cpu_we        = 1'b0;
      bus.cpu_addr      = 8'h30;
      @(posedge clk);
      for (int k = 0; k < 20 && !hs; k++) begin
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        if (bus.mem_req_valid) begin
          bus.mem_req_ready = 1'b1;
          hs = 1'b1;
        end
      end
      chk("rstmid_handshake", 32'(hs), 32'd1);
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (bus.cpu_resp_valid) seen_resp++;
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      if (bus.cpu_resp_valid) seen_resp++;
      if (bus.lru_re || bus.lru_we) seen_lru++;
      chk("rstmid_no_resp", 32'(seen_resp), 32'd0);
      chk("rstmid_no_lru", 32'(seen_lru), 32'd0);
      chk("rstmid_mem_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("rstmid_req_ready", 32'(bus.cpu_req_ready), 32'd1);
      run_req(1'b0, 8'h30, 8'h00, 8'h66, 0, o);
      chk("rstmid_reload_miss", 32'(o.mem_rd), 32'd1);
      chk("rstmid_reload_data", 32'(o.rdata), 32'h66);
      chk("rstmid_reload_way", 32'(o.way), 32'd0);
    end

    chk("lru_re_we_exclusive", 32'(r_both), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
